// File: rtl/cmd_dispatch_pkg.sv
// Shared types and constants for the oscilloscope command dispatcher.
package osc_cmd_pkg;

    typedef enum logic [7:0] {
        OP_DUMP        = 8'h01,
        OP_SET_GAIN    = 8'h02,
        OP_TRIG_LVL    = 8'h03,
        OP_TRIG_POS    = 8'h04,
        OP_DECIM       = 8'h05,
        OP_TRIG_CFG    = 8'h06,
        OP_RD_TRIG_CFG = 8'h07,
        OP_EEP_WR      = 8'h08,
        OP_EEP_RD      = 8'h09,
        OP_RD_GAIN     = 8'h0A
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SPI_WAIT,
        RESP,
        RESP_WAIT
    } state_e;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    localparam logic [2:0] SS_NONE = 3'b111;
    localparam logic [2:0] SS_EEP  = 3'd4;
    localparam logic [2:0] SS_TRIG = 3'd5;

    localparam logic [7:0] TRIG_LVL_MIN = 8'd46;
    localparam logic [7:0] TRIG_LVL_MAX = 8'd201;

    // AFE gain-stage SPI word for gain code g
    function automatic logic [15:0] gain_spi_word(input logic [2:0] g);
        logic [15:0] w;
        case (g)
            3'd0:    w = 16'h1302;
            3'd1:    w = 16'h1305;
            3'd2:    w = 16'h1309;
            3'd3:    w = 16'h1314;
            3'd4:    w = 16'h1328;
            3'd5:    w = 16'h1346;
            3'd6:    w = 16'h136B;
            default: w = 16'h13DD;
        endcase
        return w;
    endfunction

    // Clamp the trigger DAC level into the usable window
    function automatic logic [7:0] sat_trig_lvl(input logic [7:0] l);
        logic [7:0] r;
        if (l < TRIG_LVL_MIN)      r = TRIG_LVL_MIN;
        else if (l > TRIG_LVL_MAX) r = TRIG_LVL_MAX;
        else                       r = l;
        return r;
    endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Host command, SPI and UART response handshake bundle.
interface cmd_dispatch_if;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        wrt_SPI;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        SPI_done;
    logic [7:0]  EEP_data;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;

    // Environment side: command source, SPI engine and UART transmitter
    modport master (
        output cmd, cmd_rdy, SPI_done, EEP_data, resp_sent,
        input  clr_cmd_rdy, wrt_SPI, SPI_data, ss, resp_data, send_resp
    );

    // Dispatcher side
    modport slave (
        input  cmd, cmd_rdy, SPI_done, EEP_data, resp_sent,
        output clr_cmd_rdy, wrt_SPI, SPI_data, ss, resp_data, send_resp
    );
endinterface

// File: rtl/cmd_dispatch_timeout_cnt.sv
// Saturating cycle counter that flags when an SPI transaction has run too long.
module cmd_timeout_cnt #(
    parameter int unsigned MAX = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Count while enabled, hold at MAX, restart on clr
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != CNT_W'(MAX)))
            cnt_d = cnt_q + CNT_W'(1);
        expired_d = (cnt_d == CNT_W'(MAX));
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;
endmodule

// File: rtl/cmd_dispatch.sv
// Decodes host commands, drives SPI writes/reads and returns a UART response.
module cmd_dispatch
    import osc_cmd_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned TRIG_POS_W  = 9,
    parameter int unsigned DEC_W       = 4,
    parameter int unsigned SPI_TIMEOUT = 1023,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cmd_dispatch_if.slave         bus,
    output logic                  dump_en,
    output logic [CH_W-1:0]       dump_chan,
    output logic [DEC_W-1:0]      decimator,
    output logic [TRIG_POS_W-1:0] trig_pos,
    output logic [5:0]            trig_cfg,
    output logic [3*NUM_CH-1:0]   gain
);
    state_e                  state_q, state_d;
    state_e                  dec_next_q, dec_next_d;
    logic [7:0]              op_q, op_d;
    logic [2:0]              gain_ch_q, gain_ch_d;
    logic [2:0]              gain_g_q, gain_g_d;
    logic                    clr_cmd_rdy_q, clr_cmd_rdy_d;
    logic                    wrt_spi_q, wrt_spi_d;
    logic [15:0]             spi_data_q, spi_data_d;
    logic [2:0]              ss_q, ss_d;
    logic [7:0]              resp_data_q, resp_data_d;
    logic                    send_resp_q, send_resp_d;
    logic                    dump_en_q, dump_en_d;
    logic [CH_W-1:0]         dump_chan_q, dump_chan_d;
    logic [DEC_W-1:0]        decimator_q, decimator_d;
    logic [TRIG_POS_W-1:0]   trig_pos_q, trig_pos_d;
    logic [5:0]              trig_cfg_q, trig_cfg_d;
    logic [3*NUM_CH-1:0]     gain_q, gain_d;
    logic                    tmo_clr, tmo_en, tmo_expired;
    logic                    unused_cmd_bits;

    assign unused_cmd_bits = ^bus.cmd[15:14];

    cmd_timeout_cnt #(.MAX(SPI_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Next-state and next-output logic; decode happens as the command is accepted
    always_comb begin
        state_d       = state_q;
        dec_next_d    = dec_next_q;
        op_d          = op_q;
        gain_ch_d     = gain_ch_q;
        gain_g_d      = gain_g_q;
        clr_cmd_rdy_d = 1'b0;
        wrt_spi_d     = 1'b0;
        send_resp_d   = 1'b0;
        dump_en_d     = 1'b0;
        spi_data_d    = spi_data_q;
        ss_d          = ss_q;
        resp_data_d   = resp_data_q;
        dump_chan_d   = dump_chan_q;
        decimator_d   = decimator_q;
        trig_pos_d    = trig_pos_q;
        trig_cfg_d    = trig_cfg_q;
        gain_d        = gain_q;
        tmo_clr       = 1'b0;
        tmo_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    state_d       = DECODE;
                    clr_cmd_rdy_d = 1'b1;
                    op_d          = bus.cmd[23:16];
                    dec_next_d    = RESP;
                    resp_data_d   = RESP_NAK;
                    case (bus.cmd[23:16])
                        OP_DUMP: begin
                            if (32'(bus.cmd[9:8]) < NUM_CH) begin
                                dump_chan_d = CH_W'(bus.cmd[9:8]);
                                dump_en_d   = 1'b1;
                                dec_next_d  = IDLE;
                            end
                        end
                        OP_SET_GAIN: begin
                            if (32'(bus.cmd[10:8]) < NUM_CH) begin
                                ss_d       = bus.cmd[10:8];
                                spi_data_d = gain_spi_word(bus.cmd[13:11]);
                                wrt_spi_d  = 1'b1;
                                gain_ch_d  = bus.cmd[10:8];
                                gain_g_d   = bus.cmd[13:11];
                                dec_next_d = SPI_WAIT;
                            end
                        end
                        OP_TRIG_LVL: begin
                            ss_d       = SS_TRIG;
                            spi_data_d = {8'h13, sat_trig_lvl(bus.cmd[7:0])};
                            wrt_spi_d  = 1'b1;
                            dec_next_d = SPI_WAIT;
                        end
                        OP_TRIG_POS: begin
                            trig_pos_d  = bus.cmd[TRIG_POS_W-1:0];
                            resp_data_d = RESP_ACK;
                        end
                        OP_DECIM: begin
                            decimator_d = bus.cmd[DEC_W-1:0];
                            resp_data_d = RESP_ACK;
                        end
                        OP_TRIG_CFG: begin
                            trig_cfg_d  = bus.cmd[13:8];
                            resp_data_d = RESP_ACK;
                        end
                        OP_RD_TRIG_CFG: begin
                            resp_data_d = {2'b00, trig_cfg_q};
                        end
                        OP_EEP_WR: begin
                            ss_d       = SS_EEP;
                            spi_data_d = {2'b01, bus.cmd[13:0]};
                            wrt_spi_d  = 1'b1;
                            dec_next_d = SPI_WAIT;
                        end
                        OP_EEP_RD: begin
                            ss_d       = SS_EEP;
                            spi_data_d = {2'b00, bus.cmd[13:8], 8'h00};
                            wrt_spi_d  = 1'b1;
                            dec_next_d = SPI_WAIT;
                        end
                        OP_RD_GAIN: begin
                            for (int i = 0; i < int'(NUM_CH); i++) begin
                                if (bus.cmd[10:8] == 3'(i))
                                    resp_data_d = {5'b0, gain_q[3*i +: 3]};
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DECODE: begin
                tmo_clr = 1'b1;
                state_d = dec_next_q;
                if (dec_next_q == RESP)
                    send_resp_d = 1'b1;
            end
            SPI_WAIT: begin
                tmo_en = 1'b1;
                if (bus.SPI_done) begin
                    resp_data_d = (op_q == OP_EEP_RD) ? bus.EEP_data : RESP_ACK;
                    ss_d        = SS_NONE;
                    state_d     = RESP;
                    send_resp_d = 1'b1;
                    if (op_q == OP_SET_GAIN) begin
                        for (int i = 0; i < int'(NUM_CH); i++) begin
                            if (gain_ch_q == 3'(i))
                                gain_d[3*i +: 3] = gain_g_q;
                        end
                    end
                end else if (tmo_expired) begin
                    resp_data_d = RESP_NAK;
                    ss_d        = SS_NONE;
                    state_d     = RESP;
                    send_resp_d = 1'b1;
                end
            end
            RESP: begin
                state_d = RESP_WAIT;
            end
            RESP_WAIT: begin
                if (bus.resp_sent)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dec_next_q    <= IDLE;
            op_q          <= '0;
            gain_ch_q     <= '0;
            gain_g_q      <= '0;
            clr_cmd_rdy_q <= 1'b0;
            wrt_spi_q     <= 1'b0;
            spi_data_q    <= '0;
            ss_q          <= SS_NONE;
            resp_data_q   <= '0;
            send_resp_q   <= 1'b0;
            dump_en_q     <= 1'b0;
            dump_chan_q   <= '0;
            decimator_q   <= '0;
            trig_pos_q    <= '0;
            trig_cfg_q    <= '0;
            gain_q        <= '0;
        end else begin
            state_q       <= state_d;
            dec_next_q    <= dec_next_d;
            op_q          <= op_d;
            gain_ch_q     <= gain_ch_d;
            gain_g_q      <= gain_g_d;
            clr_cmd_rdy_q <= clr_cmd_rdy_d;
            wrt_spi_q     <= wrt_spi_d;
            spi_data_q    <= spi_data_d;
            ss_q          <= ss_d;
            resp_data_q   <= resp_data_d;
            send_resp_q   <= send_resp_d;
            dump_en_q     <= dump_en_d;
            dump_chan_q   <= dump_chan_d;
            decimator_q   <= decimator_d;
            trig_pos_q    <= trig_pos_d;
            trig_cfg_q    <= trig_cfg_d;
            gain_q        <= gain_d;
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd_rdy_q;
    assign bus.wrt_SPI     = wrt_spi_q;
    assign bus.SPI_data    = spi_data_q;
    assign bus.ss          = ss_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.send_resp   = send_resp_q;
    assign dump_en         = dump_en_q;
    assign dump_chan       = dump_chan_q;
    assign decimator       = decimator_q;
    assign trig_pos        = trig_pos_q;
    assign trig_cfg        = trig_cfg_q;
    assign gain            = gain_q;
endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with hand-computed expectations.
module tb_cmd_dispatch;
    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned TRIG_POS_W  = 9;
    localparam int unsigned DEC_W       = 4;
    localparam int unsigned SPI_TIMEOUT = 1023;
    localparam int unsigned CH_W        = 2;

    logic                  clk;
    logic                  rst;
    logic                  dump_en;
    logic [CH_W-1:0]       dump_chan;
    logic [DEC_W-1:0]      decimator;
    logic [TRIG_POS_W-1:0] trig_pos;
    logic [5:0]            trig_cfg;
    logic [3*NUM_CH-1:0]   gain;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_dispatch_if bus_if ();

    cmd_dispatch #(
        .NUM_CH      (NUM_CH),
        .TRIG_POS_W  (TRIG_POS_W),
        .DEC_W       (DEC_W),
        .SPI_TIMEOUT (SPI_TIMEOUT),
        .CH_W        (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dump_en   (dump_en),
        .dump_chan (dump_chan),
        .decimator (decimator),
        .trig_pos  (trig_pos),
        .trig_cfg  (trig_cfg),
        .gain      (gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one sampling edge; returns in cycle 1 (DECODE)
    task automatic issue(input logic [23:0] c);
        bus_if.cmd     = c;
        bus_if.cmd_rdy = 1'b1;
        tick();
        bus_if.cmd_rdy = 1'b0;
    endtask

    // From the send_resp cycle: move into RESP_WAIT and return resp_sent
    task automatic ack_resp();
        tick();
        bus_if.resp_sent = 1'b1;
        tick();
        bus_if.resp_sent = 1'b0;
    endtask

    // Register-style command: response in cycle 2
    task automatic reg_cmd(input string tag, input logic [23:0] c, input logic [7:0] exp_resp);
        issue(c);
        check_eq({tag, "_clr"}, 32'(bus_if.clr_cmd_rdy), 32'd1);
        check_eq({tag, "_nowrt"}, 32'(bus_if.wrt_SPI), 32'd0);
        check_eq({tag, "_nodump"}, 32'(dump_en), 32'd0);
        tick();
        check_eq({tag, "_send"}, 32'(bus_if.send_resp), 32'd1);
        check_eq({tag, "_resp"}, 32'(bus_if.resp_data), 32'(exp_resp));
        ack_resp();
    endtask

    // SPI command answered with SPI_done after 'dly' cycles
    task automatic spi_cmd(input string tag, input logic [23:0] c, input logic [2:0] exp_ss,
                           input logic [15:0] exp_data, input int dly, input logic [7:0] eep,
                           input logic [7:0] exp_resp);
        logic held;
        issue(c);
        check_eq({tag, "_wrt"}, 32'(bus_if.wrt_SPI), 32'd1);
        check_eq({tag, "_ss"}, 32'(bus_if.ss), 32'(exp_ss));
        check_eq({tag, "_data"}, 32'(bus_if.SPI_data), 32'(exp_data));
        held = 1'b1;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (bus_if.ss !== exp_ss || bus_if.SPI_data !== exp_data || bus_if.wrt_SPI !== 1'b0
                || bus_if.send_resp !== 1'b0)
                held = 1'b0;
        end
        check_eq({tag, "_held"}, 32'(held), 32'd1);
        bus_if.SPI_done = 1'b1;
        bus_if.EEP_data = eep;
        tick();
        bus_if.SPI_done = 1'b0;
        bus_if.EEP_data = 8'h00;
        check_eq({tag, "_send"}, 32'(bus_if.send_resp), 32'd1);
        check_eq({tag, "_resp"}, 32'(bus_if.resp_data), 32'(exp_resp));
        check_eq({tag, "_ssrel"}, 32'(bus_if.ss), 32'h7);
        ack_resp();
    endtask

    // SPI command never answered: expect NAK after the timeout
    task automatic spi_timeout(input string tag, input logic [23:0] c);
        int cnt;
        issue(c);
        cnt = 0;
        while (bus_if.send_resp !== 1'b1 && cnt < 1100) begin
            tick();
            cnt++;
        end
        check_eq({tag, "_window"}, 32'(cnt >= int'(SPI_TIMEOUT) && cnt <= int'(SPI_TIMEOUT) + 8), 32'd1);
        check_eq({tag, "_resp"}, 32'(bus_if.resp_data), 32'hEE);
        check_eq({tag, "_ssrel"}, 32'(bus_if.ss), 32'h7);
        ack_resp();
    endtask

    initial begin
        int clr_cnt;
        logic [7:0]  lvl_in  [3];
        logic [15:0] lvl_exp [3];
        lvl_in[0] = 8'h10; lvl_exp[0] = 16'h132E;
        lvl_in[1] = 8'hFA; lvl_exp[1] = 16'h13C9;
        lvl_in[2] = 8'h80; lvl_exp[2] = 16'h1380;

        rst              = 1'b1;
        bus_if.cmd       = '0;
        bus_if.cmd_rdy   = 1'b0;
        bus_if.SPI_done  = 1'b0;
        bus_if.EEP_data  = '0;
        bus_if.resp_sent = 1'b0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_ss", 32'(bus_if.ss), 32'h7);
        check_eq("rst_spi_data", 32'(bus_if.SPI_data), 32'h0);
        check_eq("rst_resp", 32'(bus_if.resp_data), 32'h0);
        check_eq("rst_send", 32'(bus_if.send_resp), 32'h0);
        check_eq("rst_clr", 32'(bus_if.clr_cmd_rdy), 32'h0);
        check_eq("rst_gain", 32'(gain), 32'h0);
        check_eq("rst_trig_pos", 32'(trig_pos), 32'h0);
        rst = 1'b0;
        tick();

        // Trigger position, visible in cycle 1, ACK in cycle 2
        issue(24'h04012C);
        check_eq("tpos_clr", 32'(bus_if.clr_cmd_rdy), 32'd1);
        check_eq("tpos_val", 32'(trig_pos), 32'h12C);
        tick();
        check_eq("tpos_send", 32'(bus_if.send_resp), 32'd1);
        check_eq("tpos_resp", 32'(bus_if.resp_data), 32'hA5);
        ack_resp();

        // Gain ch2 = 1, then ch0 = 7
        spi_cmd("gain_c2", 24'h020A00, 3'd2, 16'h1305, 20, 8'h00, 8'hA5);
        check_eq("gain_c2_val", 32'(gain), 32'h040);
        spi_cmd("gain_c0", 24'h023800, 3'd0, 16'h13DD, 4, 8'h00, 8'hA5);
        check_eq("gain_c0_val", 32'(gain), 32'h047);
        reg_cmd("gain_c3_nak", 24'h020300, 8'hEE);
        check_eq("gain_c3_keep", 32'(gain), 32'h047);

        // Gain readback
        reg_cmd("rdgain_c2", 24'h0A0200, 8'h01);
        reg_cmd("rdgain_c0", 24'h0A0000, 8'h07);
        reg_cmd("rdgain_c3", 24'h0A0300, 8'hEE);

        // Trigger level with saturation
        for (int i = 0; i < 3; i++)
            spi_cmd($sformatf("tlvl%0d", i), {16'h0300, lvl_in[i]}, 3'd5, lvl_exp[i], 3, 8'h00, 8'hA5);

        // EEPROM read and write
        spi_cmd("eep_rd", 24'h090500, 3'd4, 16'h0500, 6, 8'h7E, 8'h7E);
        spi_cmd("eep_wr", 24'h081234, 3'd4, 16'h5234, 2, 8'h00, 8'hA5);

        // Decimator and trigger config
        reg_cmd("decim", 24'h050007, 8'hA5);
        check_eq("decim_val", 32'(decimator), 32'h7);

        // Timeouts; a timed-out gain write leaves gain untouched
        spi_timeout("eep_tmo", 24'h080000);
        spi_timeout("gain_tmo", 24'h022900);
        check_eq("gain_tmo_keep", 32'(gain), 32'h047);

        // Dump: bad channel, illegal opcodes, then a valid dump
        reg_cmd("dump_bad", 24'h010300, 8'hEE);
        reg_cmd("op_0f", 24'h0F0000, 8'hEE);
        reg_cmd("op_00", 24'h000000, 8'hEE);
        reg_cmd("op_ff", 24'hFF0000, 8'hEE);
        issue(24'h010200);
        check_eq("dump_en", 32'(dump_en), 32'd1);
        check_eq("dump_chan", 32'(dump_chan), 32'd2);
        check_eq("dump_clr", 32'(bus_if.clr_cmd_rdy), 32'd1);
        tick();
        check_eq("dump_en_off", 32'(dump_en), 32'd0);
        check_eq("dump_no_resp", 32'(bus_if.send_resp), 32'd0);
        reg_cmd("after_dump", 24'h050003, 8'hA5);
        check_eq("after_dump_decim", 32'(decimator), 32'h3);

        // cmd_rdy held high through RESP_WAIT
        bus_if.cmd     = 24'h062A00;
        bus_if.cmd_rdy = 1'b1;
        clr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.clr_cmd_rdy === 1'b1) clr_cnt++;
        end
        check_eq("hold_clr_once", 32'(clr_cnt), 32'd1);
        check_eq("hold_trig_cfg", 32'(trig_cfg), 32'h2A);
        bus_if.resp_sent = 1'b1;
        tick();
        bus_if.resp_sent = 1'b0;
        tick();
        bus_if.cmd_rdy = 1'b0;
        check_eq("hold_rearm_clr", 32'(bus_if.clr_cmd_rdy), 32'd1);
        tick();
        check_eq("hold_rearm_resp", 32'(bus_if.resp_data), 32'hA5);
        ack_resp();
        reg_cmd("rd_trig_cfg", 24'h070000, 8'h2A);

        // Reset in the middle of an EEPROM write
        issue(24'h080000);
        repeat (10) tick();
        check_eq("midrst_ss_held", 32'(bus_if.ss), 32'h4);
        rst = 1'b1;
        tick();
        check_eq("midrst_ss", 32'(bus_if.ss), 32'h7);
        check_eq("midrst_spi", 32'(bus_if.SPI_data), 32'h0);
        check_eq("midrst_gain", 32'(gain), 32'h0);
        check_eq("midrst_tpos", 32'(trig_pos), 32'h0);
        check_eq("midrst_tcfg", 32'(trig_cfg), 32'h0);
        check_eq("midrst_resp", 32'(bus_if.resp_data), 32'h0);
        check_eq("midrst_pulses", 32'({bus_if.send_resp, bus_if.wrt_SPI, bus_if.clr_cmd_rdy, dump_en}), 32'h0);
        rst = 1'b0;
        tick();
        reg_cmd("post_rst", 24'h050009, 8'hA5);
        check_eq("post_rst_decim", 32'(decimator), 32'h9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
